multicycle_acc_controller: RTL

//   Parametrised multicycle control FSM for the accumulator CPU. Next generation of the single-AC controller.

---
 rtl/multicycle_acc_controller.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_acc_controller.sv
// Multicycle control FSM for the accumulator CPU: fetch/decode, memory and register-file
// accumulator instructions, jumps, halt, a memory-wait watchdog and illegal-opcode reporting.
module multicycle_acc_controller #(
    parameter int OPC_W     = 4,
    parameter int ALU_CMD_W = 3,
    parameter int TIMEOUT   = 16,
    parameter int TMO_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPC_W-1:0]     opcode_i,
    input  logic                 zero_flag_i,
    input  logic                 mem_ready_i,
    output logic                 pc_write_o,
    output logic                 pc_src_o,
    output logic                 mem_addr_sel_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic                 ir_write1_o,
    output logic                 ir_write2_o,
    output logic                 ac_read_o,
    output logic                 ac_write_o,
    output logic                 ac_addr_sel_o,
    output logic [1:0]           ac_data_sel_o,
    output logic                 alu_b_sel_o,
    output logic [ALU_CMD_W-1:0] alu_cmd_o,
    output logic                 halted_o,
    output logic                 illegal_o,
    output logic                 err_o
);

    typedef enum logic [4:0] {
        FETCH1, DECODE, FETCH2,
        LDA_RD, LDA_WB, STA_RD, STA_WR,
        MA_RD, MA_EX, MA_WB,
        JMP, JZ,
        R_RD, R_EX, R_WB,
        HALT, ERR
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0, OP_STA = 4'h1, OP_ADA = 4'h2, OP_ANA = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4, OP_JZ  = 4'h5, OP_MVR = 4'h8, OP_ADR = 4'h9;
    localparam logic [3:0] OP_ANR = 4'hA, OP_ORR = 4'hB, OP_NOT = 4'hC, OP_HLT = 4'hF;

    localparam logic [ALU_CMD_W-1:0] ALU_ADD  = ALU_CMD_W'(0);
    localparam logic [ALU_CMD_W-1:0] ALU_AND  = ALU_CMD_W'(1);
    localparam logic [ALU_CMD_W-1:0] ALU_OR   = ALU_CMD_W'(2);
    localparam logic [ALU_CMD_W-1:0] ALU_NOTA = ALU_CMD_W'(3);

    localparam logic [TMO_W-1:0] WDOG_LIMIT = TMO_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   wdogCount_q, wdogCount_d;
    logic               illegal_q, illegal_d;
    logic [3:0]         op;
    logic               memState;
    logic [ALU_CMD_W-1:0] maCmd, regCmd;

    assign op = opcode_i[OPC_W-1 -: 4];

    assign memState = (state_q == FETCH1) || (state_q == FETCH2) || (state_q == LDA_RD) ||
                      (state_q == STA_WR) || (state_q == MA_RD);

    assign maCmd = (op == OP_ANA) ? ALU_AND : ALU_ADD;

    always_comb begin
        case (op)
            OP_ANR:  regCmd = ALU_AND;
            OP_ORR:  regCmd = ALU_OR;
            OP_NOT:  regCmd = ALU_NOTA;
            default: regCmd = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wdogCount_d = '0;
        illegal_d   = illegal_q;
        case (state_q)
            FETCH1: if (mem_ready_i) state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LDA, OP_STA, OP_ADA, OP_ANA, OP_JMP, OP_JZ: state_d = FETCH2;
                    OP_MVR, OP_ADR, OP_ANR, OP_ORR, OP_NOT:        state_d = R_RD;
                    OP_HLT:                                        state_d = HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = FETCH1;
                    end
                endcase
            end
            FETCH2: begin
                if (mem_ready_i) begin
                    case (op)
                        OP_LDA:         state_d = LDA_RD;
                        OP_STA:         state_d = STA_RD;
                        OP_ADA, OP_ANA: state_d = MA_RD;
                        OP_JMP:         state_d = JMP;
                        default:        state_d = JZ;
                    endcase
                end
            end
            LDA_RD: if (mem_ready_i) state_d = LDA_WB;
            LDA_WB: state_d = FETCH1;
            STA_RD: state_d = STA_WR;
            STA_WR: if (mem_ready_i) state_d = FETCH1;
            MA_RD:  if (mem_ready_i) state_d = MA_EX;
            MA_EX:  state_d = MA_WB;
            MA_WB:  state_d = FETCH1;
            JMP:    state_d = FETCH1;
            JZ:     state_d = FETCH1;
            R_RD:   state_d = R_EX;
            R_EX:   state_d = R_WB;
            R_WB:   state_d = FETCH1;
            HALT:   state_d = HALT;
            ERR:    state_d = ERR;
            default: state_d = FETCH1;
        endcase
        // A completing access always wins over the watchdog limit in the same cycle.
        if (memState && !mem_ready_i) begin
            if (wdogCount_q == WDOG_LIMIT) begin
                state_d = ERR;
            end else begin
                wdogCount_d = wdogCount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH1;
            wdogCount_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wdogCount_q <= wdogCount_d;
            illegal_q   <= illegal_d;
        end
    end

    // Strobes are decoded from the state register but qualified by mem_ready/zero_flag in the
    // same cycle; rst gates them so an aborted instruction never emits a partial write.
    always_comb begin
        pc_write_o     = 1'b0;
        pc_src_o       = 1'b0;
        mem_addr_sel_o = 1'b0;
        mem_read_o     = 1'b0;
        mem_write_o    = 1'b0;
        ir_write1_o    = 1'b0;
        ir_write2_o    = 1'b0;
        ac_read_o      = 1'b0;
        ac_write_o     = 1'b0;
        ac_addr_sel_o  = 1'b0;
        ac_data_sel_o  = 2'd0;
        alu_b_sel_o    = 1'b0;
        alu_cmd_o      = ALU_ADD;
        halted_o       = 1'b0;
        illegal_o      = 1'b0;
        err_o          = 1'b0;
        if (!rst) begin
            illegal_o = illegal_q;
            case (state_q)
                FETCH1: begin
                    mem_read_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_write1_o = 1'b1;
                        pc_write_o  = 1'b1;
                    end
                end
                FETCH2: begin
                    mem_read_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_write2_o = 1'b1;
                        pc_write_o  = 1'b1;
                    end
                end
                LDA_RD: begin
                    mem_read_o     = 1'b1;
                    mem_addr_sel_o = 1'b1;
                end
                LDA_WB: ac_write_o = 1'b1;
                STA_RD: ac_read_o = 1'b1;
                STA_WR: begin
                    mem_write_o    = 1'b1;
                    mem_addr_sel_o = 1'b1;
                end
                MA_RD: begin
                    ac_read_o      = 1'b1;
                    mem_read_o     = 1'b1;
                    mem_addr_sel_o = 1'b1;
                end
                MA_EX: alu_cmd_o = maCmd;
                MA_WB: begin
                    ac_write_o    = 1'b1;
                    ac_data_sel_o = 2'd1;
                    alu_cmd_o     = maCmd;
                end
                JMP: begin
                    pc_write_o = 1'b1;
                    pc_src_o   = 1'b1;
                end
                JZ: begin
                    pc_write_o = zero_flag_i;
                    pc_src_o   = zero_flag_i;
                end
                R_RD: begin
                    ac_read_o     = 1'b1;
                    ac_addr_sel_o = 1'b1;
                end
                R_EX: begin
                    ac_read_o   = 1'b1;
                    alu_b_sel_o = 1'b1;
                    alu_cmd_o   = regCmd;
                end
                R_WB: begin
                    ac_write_o    = 1'b1;
                    ac_data_sel_o = (op == OP_MVR) ? 2'd2 : 2'd1;
                end
                HALT: halted_o = 1'b1;
                ERR:  err_o = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
